// File: rtl/sram_pixel_reader_pkg.sv
// Shared VGA/SRAM definitions: default geometry and reader FSM states.
// Also imported by BTNandSRAM_control.
package sram_pixel_reader_pkg;

  localparam int unsigned ADDR_W_DEF      = 20;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned FRAME_WORDS_DEF = 307200;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sram_pixel_reader_if.sv
// SRAM bus plus bus arbitration handshake between the pixel reader and the SRAM side.
interface sram_pixel_reader_if
  import sram_pixel_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_in;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport master (
    output bus_req, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    input  bus_gnt, sram_dq_in
  );

  modport slave (
    input  bus_req, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    output bus_gnt, sram_dq_in
  );
endinterface

// File: rtl/sram_pixel_reader_pix_fifo.sv
// Single-clock prefetch FIFO with flush and occupancy count; DEPTH must be a power of 2 (>= 2).
module pix_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sram_pixel_reader.sv
// Frame-synchronous SRAM reader: prefetches pixel words into a small FIFO and serves
// one word per VGA pixel request, flagging underflow when the FIFO runs dry.
module sram_pixel_reader
  import sram_pixel_reader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                pixel_clk,
  input  logic                reset_n,
  input  logic                EoFrame,
  input  logic                pix_req,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_valid,
  output logic                underflow,
  sram_pixel_reader_if.master sram
);
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W:0]    DEPTH_CNT = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue;
  logic              cap_valid_q;
  logic [DATA_W-1:0] cap_data_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W:0]    occupancy;

  // The capture register is the in-flight slot: it counts against FIFO space until pushed.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, cap_valid_q};
  assign issue     = (state_q == ST_RUN) && sram.bus_gnt && (occupancy < DEPTH_CNT);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    sram.bus_req   = 1'b0;
    sram.sram_addr = addr_q;
    sram.sram_ce_n = 1'b1;
    sram.sram_oe_n = 1'b1;
    sram.sram_we_n = 1'b1;
    sram.sram_ub_n = 1'b1;
    sram.sram_lb_n = 1'b1;
    case (state_q)
      ST_RUN: begin
        sram.bus_req = 1'b1;
        if (issue) begin
          sram.sram_ce_n = 1'b0;
          sram.sram_oe_n = 1'b0;
          sram.sram_ub_n = 1'b0;
          sram.sram_lb_n = 1'b0;
          if (addr_q == LAST_ADDR) state_d = ST_DONE;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      ST_IDLE, ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (EoFrame) begin
      state_d = ST_RUN;
      addr_d  = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
    end else begin
      cap_valid_q <= issue && !EoFrame;
      if (issue) cap_data_q <= sram.sram_dq_in;
    end
  end

  pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pixel_clk),
    .rst_n (reset_n),
    .flush (EoFrame),
    .push  (cap_valid_q && !EoFrame),
    .pop   (pix_req),
    .wdata (cap_data_q),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if (pix_req) begin
        if (!fifo_empty) begin
          pix_data  <= fifo_head;
          pix_valid <= 1'b1;
        end else begin
          pix_data  <= '0;
          underflow <= 1'b1;
        end
      end
      if (EoFrame) underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sram_pixel_reader.sv
// Randomized bench for sram_pixel_reader against a queue-based frame/FIFO reference model.
module tb_sram_pixel_reader;
  import sram_pixel_reader_pkg::*;

  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 16;
  localparam int unsigned FW    = 200;
  localparam int unsigned DEPTH = 4;

  logic          pixel_clk = 1'b0;
  logic          reset_n   = 1'b0;
  logic          EoFrame   = 1'b0;
  logic          pix_req   = 1'b0;
  logic          gnt       = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;
  logic [3:0]    frame_tag = 4'd0;

  sram_pixel_reader_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  sram_pixel_reader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .EoFrame   (EoFrame),
    .pix_req   (pix_req),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .underflow (underflow),
    .sram      (sif.master)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a, input logic [3:0] tag);
    return DW'(a) ^ {tag, 12'h000};
  endfunction

  assign sif.bus_gnt = gnt;
  always_comb sif.sram_dq_in = sram_word(sif.sram_addr, frame_tag);

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [DW-1:0] mq[$];
  bit            m_infl      = 1'b0;
  logic [DW-1:0] m_infl_data = '0;
  int unsigned   m_addr      = 0;
  bit            m_fetching  = 1'b0;
  logic [DW-1:0] m_pix_data  = '0;
  bit            m_pix_valid = 1'b0;
  bit            m_underflow = 1'b0;
  int unsigned   issues_seen = 0;
  logic [AW-1:0] last_addr   = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_will_issue(input bit g);
    int occ;
    occ = mq.size() + int'(m_infl);
    return m_fetching && g && (occ < int'(DEPTH));
  endfunction

  task automatic step(input bit eof, input bit req, input bit g);
    bit exp_issue;
    @(negedge pixel_clk);
    EoFrame = eof;
    pix_req = req;
    gnt     = g;
    exp_issue = model_will_issue(g);
    #1;
    check_val("bus_req", 32'(sif.bus_req), 32'(m_fetching));
    check_val("ctl_n", 32'({sif.sram_ce_n, sif.sram_oe_n, sif.sram_ub_n, sif.sram_lb_n}),
              exp_issue ? 32'h0 : 32'hf);
    check_val("we_n", 32'(sif.sram_we_n), 32'h1);
    if (exp_issue) check_val("sram_addr", 32'(sif.sram_addr), m_addr);
    if (sif.sram_ce_n === 1'b0) begin
      issues_seen++;
      last_addr = sif.sram_addr;
    end
    @(posedge pixel_clk);
    m_pix_valid = 1'b0;
    if (req) begin
      if (mq.size() > 0) begin
        m_pix_data  = mq.pop_front();
        m_pix_valid = 1'b1;
      end else begin
        m_pix_data  = '0;
        m_underflow = 1'b1;
      end
    end
    if (eof) begin
      mq.delete();
      m_infl      = 1'b0;
      m_underflow = 1'b0;
      m_addr      = 0;
      m_fetching  = 1'b1;
    end else begin
      if (m_infl) mq.push_back(m_infl_data);
      m_infl = exp_issue;
      if (exp_issue) begin
        m_infl_data = sram_word(AW'(m_addr), frame_tag);
        if (m_addr == FW - 1) m_fetching = 1'b0;
        else                  m_addr++;
      end
    end
    #1;
    if (eof) frame_tag = frame_tag + 4'd1;
    check_val("pix_valid", 32'(pix_valid), 32'(m_pix_valid));
    check_val("pix_data", 32'(pix_data), 32'(m_pix_data));
    check_val("underflow", 32'(underflow), 32'(m_underflow));
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_pix_data"}, 32'(pix_data), 32'h0);
    check_val({tag, "_pix_valid"}, 32'(pix_valid), 32'h0);
    check_val({tag, "_underflow"}, 32'(underflow), 32'h0);
    check_val({tag, "_bus_req"}, 32'(sif.bus_req), 32'h0);
    check_val({tag, "_sram_addr"}, 32'(sif.sram_addr), 32'h0);
    check_val({tag, "_ctl_n"}, 32'({sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n,
                                   sif.sram_ub_n, sif.sram_lb_n}), 32'h1f);
  endtask

  initial begin
    int unsigned base;
    int unsigned budget;

    #1;
    check_reset_values("por");
    #11;
    reset_n = 1'b1;

    // Idle after reset: no reads before the first end-of-frame
    base = issues_seen;
    repeat (4) step(1'b0, 1'b0, 1'b1);
    check_val("no_read_before_eof", issues_seen - base, 0);

    // Prefetch fills exactly FIFO_DEPTH words, then the bus goes quiet
    step(1'b1, 1'b0, 1'b1);
    base = issues_seen;
    repeat (10) step(1'b0, 1'b0, 1'b1);
    check_val("prefill_reads", issues_seen - base, DEPTH);
    check_val("prefill_last_addr", 32'(last_addr), DEPTH - 1);

    // Continuous consumption: one read per cycle in steady state, no underflow
    repeat (30) step(1'b0, 1'b1, 1'b1);
    base = issues_seen;
    repeat (10) step(1'b0, 1'b1, 1'b1);
    check_val("steady_reads", issues_seen - base, 10);
    check_val("steady_underflow", 32'(underflow), 32'h0);

    // Grant withdrawn: FIFO drains, underflow latches, no bus activity
    base = issues_seen;
    repeat (10) step(1'b0, 1'b1, 1'b0);
    check_val("gap_reads", issues_seen - base, 0);
    check_val("gap_underflow", 32'(underflow), 32'h1);
    repeat (5) step(1'b0, 1'b1, 1'b1);

    // Random consumption/grant until the frame has been fully fetched
    budget = 0;
    while (m_fetching && budget < 3000) begin
      step(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8));
      budget++;
    end
    check_val("frame_done_in_budget", 32'(budget < 3000), 32'h1);
    check_val("last_frame_addr", 32'(last_addr), FW - 1);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    check_val("done_bus_req", 32'(sif.bus_req), 32'h0);
    check_val("done_underflow", 32'(underflow), 32'h1);
    check_val("done_pix_data", 32'(pix_data), 32'h0);

    // Restart, then end-of-frame lands on the cycle issuing address 100
    step(1'b1, 1'b0, 1'b1);
    check_val("restart_underflow_clr", 32'(underflow), 32'h0);
    budget = 0;
    while (!(m_addr == 100 && model_will_issue(1'b1)) && budget < 1000) begin
      step(1'b0, ($urandom_range(0, 9) < 8), 1'b1);
      budget++;
    end
    check_val("reach_addr100", 32'(m_addr), 100);
    step(1'b1, 1'b0, 1'b1);
    check_val("eof_issue_addr100", 32'(last_addr), 100);
    step(1'b0, 1'b0, 1'b1);
    check_val("restart_addr0", 32'(last_addr), 0);
    repeat (40) step(1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 9));

    // Asynchronous reset between edges while the reader is running
    @(negedge pixel_clk);
    EoFrame = 1'b0;
    pix_req = 1'b1;
    gnt     = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    mq.delete();
    m_infl      = 1'b0;
    m_addr      = 0;
    m_fetching  = 1'b0;
    m_pix_data  = '0;
    m_pix_valid = 1'b0;
    m_underflow = 1'b0;
    pix_req     = 1'b0;
    @(posedge pixel_clk);
    #2;
    reset_n = 1'b1;
    base = issues_seen;
    repeat (8) step(1'b0, 1'b1, 1'b1);
    check_val("post_reset_reads", issues_seen - base, 0);

    // Recovery on the next frame
    step(1'b1, 1'b0, 1'b1);
    repeat (30) step(1'b0, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
